axicb_slv_rd_sched: RTL and testbench

Read-side scheduler for one slave port of the crossbar. It shares that slave's AR channel between MST_NB master-side read switches using locked round-robin arbitration, and bounds the number of reads in flight at the slave. It returns R beats to the issuing master by decoding the ID prefix. It sits between the per-master read switches and one slave interface.

---
 rtl/axicb_pkg.sv | 33 +++
 rtl/axicb_round_robin.sv | 36 +++
 rtl/axicb_slv_rd_sched.sv | 171 +++++++++++++++++
 tb/tb_axicb_slv_rd_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axicb_pkg.sv
// ----------------------------------------------------------------------------
// axicb_pkg: shared crossbar types and ID-mask helper.          Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axicb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } route_state_t;

  // Union of the ID prefixes actually in use; unused masters contribute nothing.
  function automatic logic [31:0] mask_all(input int mst_nb,
                                           input logic [31:0] m0,
                                           input logic [31:0] m1,
                                           input logic [31:0] m2,
                                           input logic [31:0] m3);
    logic [31:0] acc;
    acc = m0 | m1;
    if (mst_nb > 2) acc = acc | m2;
    if (mst_nb > 3) acc = acc | m3;
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axicb_round_robin.sv
// ----------------------------------------------------------------------------
// axicb_round_robin: first requester at or after the pointer wins. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axicb_round_robin #(
  parameter int MST_NB = 4
) (
  input  logic [MST_NB-1:0]         i_req,
  input  logic [$clog2(MST_NB)-1:0] i_ptr,
  output logic [MST_NB-1:0]         o_grant
);

  logic w_found;

  // Upper pass covers [ptr, MST_NB), lower pass wraps around to [0, ptr).
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < MST_NB; k++) begin
      if (!w_found && i_req[k] && (k >= int'(i_ptr))) begin
        o_grant[k] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int k = 0; k < MST_NB; k++) begin
      if (!w_found && i_req[k] && (k < int'(i_ptr))) begin
        o_grant[k] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axicb_slv_rd_sched.sv
// ----------------------------------------------------------------------------
// axicb_slv_rd_sched: slave-side AR arbiter, outstanding limiter, R router. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axicb_slv_rd_sched
  import axicb_pkg::*;
#(
  parameter int                  AXI_ID_W        = 8,
  parameter int                  MST_NB          = 4,
  parameter int                  SLV_OSTDREQ_NUM = 4,
  parameter logic [AXI_ID_W-1:0] MST0_ID_MASK    = 'h10,
  parameter logic [AXI_ID_W-1:0] MST1_ID_MASK    = 'h20,
  parameter logic [AXI_ID_W-1:0] MST2_ID_MASK    = 'h30,
  parameter logic [AXI_ID_W-1:0] MST3_ID_MASK    = 'h40,
  parameter int                  ARCH_W          = 8,
  parameter int                  RCH_W           = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic [MST_NB-1:0]        i_arvalid,
  output logic [MST_NB-1:0]        i_arready,
  input  logic [MST_NB*ARCH_W-1:0] i_arch,
  output logic [MST_NB-1:0]        i_rvalid,
  input  logic [MST_NB-1:0]        i_rready,
  output logic [MST_NB-1:0]        i_rlast,
  output logic [RCH_W-1:0]         i_rch,
  output logic                     o_arvalid,
  input  logic                     o_arready,
  output logic [ARCH_W-1:0]        o_arch,
  input  logic                     o_rvalid,
  output logic                     o_rready,
  input  logic                     o_rlast,
  input  logic [RCH_W-1:0]         o_rch,
  output logic                     o_rid_err
);

  localparam int c_ptr_w = $clog2(MST_NB);
  localparam int c_cnt_w = $clog2(SLV_OSTDREQ_NUM + 1);
  localparam logic [AXI_ID_W-1:0] c_mask_all = AXI_ID_W'(mask_all(MST_NB,
      32'(MST0_ID_MASK), 32'(MST1_ID_MASK), 32'(MST2_ID_MASK), 32'(MST3_ID_MASK)));
  localparam logic [4*AXI_ID_W-1:0] c_masks =
      {MST3_ID_MASK, MST2_ID_MASK, MST1_ID_MASK, MST0_ID_MASK};

  sched_state_t        r_ar_state, w_ar_state_nxt;
  route_state_t        r_r_state, w_r_state_nxt;
  logic [c_ptr_w-1:0]  r_gnt, w_gnt_nxt, r_ptr, w_ptr_nxt, w_win_idx;
  logic [c_cnt_w-1:0]  r_ostd, w_ostd_nxt;
  logic [MST_NB-1:0]   r_route, w_route_nxt, w_win, w_dec, w_route;
  logic                r_rseen, w_rseen_nxt;
  logic                w_ar_hs, w_r_hs, w_rlast_hs, w_ostd_full, w_hit;

  axicb_round_robin #(.MST_NB(MST_NB)) u_rr (
    .i_req   (i_arvalid),
    .i_ptr   (r_ptr),
    .o_grant (w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int k = 0; k < MST_NB; k++) begin
      if (w_win[k]) w_win_idx = c_ptr_w'(k);
    end
  end

  assign w_ar_hs     = (r_ar_state == GRANT) & i_arvalid[r_gnt] & o_arready;
  assign w_r_hs      = o_rvalid & o_rready;
  assign w_rlast_hs  = w_r_hs & o_rlast;
  assign w_ostd_full = (r_ostd >= c_cnt_w'(SLV_OSTDREQ_NUM));

  // AR arbitration: the grant stays locked on one master until its handshake.
  always_comb begin
    w_ar_state_nxt = r_ar_state;
    w_gnt_nxt      = r_gnt;
    w_ptr_nxt      = r_ptr;
    o_arvalid      = 1'b0;
    i_arready      = '0;
    o_arch         = i_arch[r_gnt*ARCH_W +: ARCH_W];
    case (r_ar_state)
      IDLE: begin
        if ((|i_arvalid) && !w_ostd_full) begin
          w_gnt_nxt      = w_win_idx;
          w_ar_state_nxt = GRANT;
        end
      end
      GRANT: begin
        o_arvalid        = i_arvalid[r_gnt];
        i_arready[r_gnt] = o_arready;
        if (w_ar_hs) begin
          w_ar_state_nxt = IDLE;
          w_ptr_nxt      = (int'(r_gnt) == MST_NB - 1) ? '0 : r_gnt + 1'b1;
        end
      end
      default: w_ar_state_nxt = IDLE;
    endcase
    if (srst) begin
      w_ar_state_nxt = IDLE;
      w_gnt_nxt      = '0;
      w_ptr_nxt      = '0;
    end
  end

  always_comb begin
    for (int m = 0; m < MST_NB; m++) begin
      w_dec[m] = ((o_rch[0 +: AXI_ID_W] & c_mask_all) == c_masks[m*AXI_ID_W +: AXI_ID_W]);
    end
  end

  // A route of all zeros means the ID belongs to nobody: drain and flag it.
  assign w_route   = (r_r_state == R_BURST) ? r_route : w_dec;
  assign w_hit     = |w_route;
  assign o_rready  = (o_rvalid | r_rseen) & (w_hit ? |(w_route & i_rready) : 1'b1);
  assign i_rvalid  = w_route & {MST_NB{o_rvalid}};
  assign i_rlast   = w_route & {MST_NB{o_rlast}};
  assign i_rch     = o_rch;
  assign o_rid_err = w_rlast_hs & ~w_hit;

  always_comb begin
    w_r_state_nxt = r_r_state;
    w_route_nxt   = r_route;
    w_rseen_nxt   = r_rseen | o_rvalid;
    w_ostd_nxt    = r_ostd;
    case (r_r_state)
      R_IDLE: begin
        if (w_r_hs && !o_rlast) begin
          w_route_nxt   = w_dec;
          w_r_state_nxt = R_BURST;
        end
      end
      R_BURST: begin
        if (w_rlast_hs) w_r_state_nxt = R_IDLE;
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
    if (w_ar_hs && !w_rlast_hs && !w_ostd_full) begin
      w_ostd_nxt = r_ostd + 1'b1;
    end else if (!w_ar_hs && w_rlast_hs && (r_ostd != '0)) begin
      w_ostd_nxt = r_ostd - 1'b1;
    end
    if (srst) begin
      w_r_state_nxt = R_IDLE;
      w_route_nxt   = '0;
      w_rseen_nxt   = 1'b0;
      w_ostd_nxt    = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ar_state <= IDLE;
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_ostd     <= '0;
      r_r_state  <= R_IDLE;
      r_route    <= '0;
      r_rseen    <= 1'b0;
    end else begin
      r_ar_state <= w_ar_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_ostd     <= w_ostd_nxt;
      r_r_state  <= w_r_state_nxt;
      r_route    <= w_route_nxt;
      r_rseen    <= w_rseen_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axicb_slv_rd_sched.sv
// ----------------------------------------------------------------------------
// tb_axicb_slv_rd_sched: directed + random bench against a transaction model. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axicb_slv_rd_sched;

  localparam int NB = 4, IDW = 8, AW = 8, RW = 16, OSTD = 2;

  logic            aclk = 1'b0, aresetn, srst;
  logic [NB-1:0]   i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [NB*AW-1:0] i_arch;
  logic [RW-1:0]   i_rch, o_rch;
  logic [AW-1:0]   o_arch;
  logic            o_arvalid, o_arready, o_rvalid, o_rready, o_rlast, o_rid_err;

  always #5 aclk = ~aclk;

  axicb_slv_rd_sched #(
    .AXI_ID_W(IDW), .MST_NB(NB), .SLV_OSTDREQ_NUM(OSTD), .ARCH_W(AW), .RCH_W(RW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
    .o_rid_err(o_rid_err)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transaction-level model: current grant owner, RR pointer, reads in flight,
  // owner of the burst in progress.
  int  m_gnt, m_ptr, m_ostd, m_route, e_route, hs_mst;
  bit  m_inburst, m_seen, e_rready, r_hs;
  int  hs_log[$];
  longint hs_cyc[$];
  longint cyc = 0;
  int  dut_err = 0, dut_last1 = 0;
  int  dut_beats[NB];
  int  rq[$];
  int  rb_rem = 0;
  logic [IDW-1:0] rb_id;

  function automatic int id_owner(input logic [IDW-1:0] id);
    logic [IDW-1:0] msk;
    for (int m = 0; m < NB; m++) begin
      msk = 8'((m + 1) * 16);
      if ((id & 8'h70) == msk) return m;
    end
    return -1;
  endfunction

  function automatic int rr_pick(input logic [NB-1:0] req, input int ptr);
    for (int k = 0; k < NB; k++) if (req[(ptr + k) % NB]) return (ptr + k) % NB;
    return -1;
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_ptr = 0; m_ostd = 0; m_route = -1; m_inburst = 0; m_seen = 0;
  endtask

  task automatic check_cycle();
    logic [NB-1:0] e_arrdy, e_rv, e_rl;
    logic [AW-1:0] e_arch;
    bit e_arv, e_err;
    if (!aresetn) model_reset();
    e_arrdy = '0; e_arv = 1'b0; e_arch = '0;
    if (m_gnt >= 0) begin
      e_arv = i_arvalid[m_gnt];
      e_arrdy[m_gnt] = o_arready;
      e_arch = i_arch[m_gnt*AW +: AW];
    end
    chk("ar_valid", o_arvalid, e_arv);
    chk("ar_ready", i_arready, e_arrdy);
    if (e_arv) chk("ar_payload", o_arch, e_arch);
    e_route = m_inburst ? m_route : id_owner(o_rch[IDW-1:0]);
    e_rv = '0; e_rl = '0; e_rready = 1'b1;
    if (e_route >= 0) begin
      e_rv[e_route] = o_rvalid;
      e_rl[e_route] = o_rlast;
      e_rready = i_rready[e_route];
    end
    if (!(m_seen || o_rvalid)) e_rready = 1'b0;
    e_err = o_rvalid && e_rready && o_rlast && (e_route < 0);
    chk("r_valid", i_rvalid, e_rv);
    chk("r_last", i_rlast, e_rl);
    chk("r_ready", o_rready, e_rready);
    chk("rid_err", o_rid_err, e_err);
    chk("r_payload", i_rch, o_rch);
    if (o_rid_err) dut_err++;
    if (i_rvalid[1] && i_rready[1] && i_rlast[1]) dut_last1++;
    for (int m = 0; m < NB; m++) if (i_rvalid[m] && i_rready[m]) dut_beats[m]++;
  endtask

  task automatic update();
    bit ar_hs, rl_hs;
    hs_mst = -1; r_hs = 1'b0;
    if (!aresetn || srst) begin
      model_reset();
      return;
    end
    ar_hs = (m_gnt >= 0) && i_arvalid[m_gnt] && o_arready;
    r_hs  = o_rvalid && e_rready;
    rl_hs = r_hs && o_rlast;
    if (m_gnt >= 0) begin
      if (ar_hs) begin
        hs_mst = m_gnt;
        hs_log.push_back(m_gnt);
        hs_cyc.push_back(cyc);
        m_ptr = (m_gnt + 1) % NB;
        m_gnt = -1;
      end
    end else if (i_arvalid != '0 && m_ostd < OSTD) begin
      m_gnt = rr_pick(i_arvalid, m_ptr);
    end
    if (ar_hs && !rl_hs) m_ostd++;
    else if (!ar_hs && rl_hs && m_ostd > 0) m_ostd--;
    if (o_rvalid) m_seen = 1'b1;
    if (r_hs) begin
      if (o_rlast) m_inburst = 1'b0;
      else if (!m_inburst) begin
        m_inburst = 1'b1;
        m_route = e_route;
      end
    end
  endtask

  task automatic step();
    @(negedge aclk);
    check_cycle();
    update();
    @(posedge aclk);
    #1;
    cyc++;
    if (hs_mst >= 0) i_arvalid[hs_mst] = 1'b0;
    if (r_hs) begin
      o_rvalid = 1'b0;
      o_rlast  = 1'b0;
    end
  endtask

  task automatic wait_ar(input int target);
    int t;
    t = 0;
    while (hs_log.size() < target && t < 50) begin
      step();
      t++;
    end
    chk("ar_done", hs_log.size() >= target, 1'b1);
  endtask

  task automatic rbeat(input logic [IDW-1:0] id, input bit last, input bit tog);
    int t;
    t = 0;
    o_rvalid = 1'b1; o_rlast = last; o_rch = {8'($urandom), id};
    do begin
      if (tog) i_rready[1] = ~i_rready[1];
      step();
      t++;
    end while (!r_hs && t < 50);
    chk("r_done", r_hs, 1'b1);
    o_rvalid = 1'b0; o_rlast = 1'b0;
  endtask

  task automatic rand_drive();
    int m;
    for (int k = 0; k < NB; k++) begin
      if (!i_arvalid[k] && $urandom_range(3) == 0) begin
        i_arvalid[k] = 1'b1;
        i_arch[k*AW +: AW] = 8'($urandom);
      end
    end
    o_arready = 1'($urandom);
    i_rready  = 4'($urandom);
    if (rb_rem == 0 && rq.size() > 0 && $urandom_range(1) == 1) begin
      m = rq.pop_front();
      rb_id = ($urandom_range(7) == 0) ? {4'h0, 4'($urandom)}
                                       : {1'($urandom), 3'(m + 1), 4'($urandom)};
      rb_rem = int'($urandom_range(4, 1));
    end
    if (rb_rem > 0 && !o_rvalid && $urandom_range(2) != 0) begin
      o_rvalid = 1'b1;
      o_rlast  = (rb_rem == 1);
      o_rch    = {8'($urandom), rb_id};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, b2, b3, e0, l0;
    model_reset();
    for (int m = 0; m < NB; m++) dut_beats[m] = 0;
    aresetn = 1'b0; srst = 1'b0;
    i_arvalid = '0; i_arch = 32'h44332211; i_rready = '1;
    o_arready = 1'b0; o_rvalid = 1'b0; o_rlast = 1'b0; o_rch = '0;
    repeat (3) step();
    chk("reset_outputs", {o_arvalid, i_arready, i_rvalid, i_rlast, o_rid_err, o_rready}, '0);
    aresetn = 1'b1;

    // Masters 0 and 2 together: 0 first, 2 two cycles later.
    o_arready = 1'b1; i_arvalid = 4'b0101;
    wait_ar(2);
    chk("first_grant", hs_log[0], 0);
    chk("second_grant", hs_log[1], 2);
    chk("grant_spacing", hs_cyc[1] - hs_cyc[0], 2);

    // Two reads in flight: further requests wait until an R last returns.
    i_arvalid = 4'b1010;
    repeat (4) step();
    chk("sat_hold_valid", o_arvalid, 1'b0);
    chk("sat_hold_count", hs_log.size(), 2);
    rbeat(8'h10, 1'b1, 1'b0);
    wait_ar(3);
    chk("ptr_after_2", hs_log[2], 3);

    // Locked grant on master 1 while the slave stalls and master 3 requests.
    o_arready = 1'b0;
    rbeat(8'h35, 1'b1, 1'b0);
    step();
    i_arvalid[3] = 1'b1;
    repeat (5) step();
    chk("lock_valid", o_arvalid, 1'b1);
    chk("lock_ready", i_arready, '0);
    chk("lock_count", hs_log.size(), 3);
    o_arready = 1'b1;
    wait_ar(4);
    chk("lock_owner", hs_log[3], 1);
    o_arready = 1'b0;

    // 4-beat burst for master 1 under toggling backpressure.
    b0 = dut_beats[0]; b1 = dut_beats[1]; b2 = dut_beats[2]; b3 = dut_beats[3];
    l0 = dut_last1;
    i_rready = 4'b1111;
    for (int k = 0; k < 4; k++) rbeat(8'h23, (k == 3), 1'b1);
    chk("burst_m1_beats", dut_beats[1] - b1, 4);
    chk("burst_other_beats", (dut_beats[0] - b0) + (dut_beats[2] - b2) + (dut_beats[3] - b3), 0);
    chk("burst_m1_last", dut_last1 - l0, 1);

    // Unmatched ID is drained even with every master stalled.
    e0 = dut_err;
    i_rready = 4'b0000;
    rbeat(8'h05, 1'b0, 1'b0);
    rbeat(8'h05, 1'b1, 1'b0);
    chk("rid_err_pulses", dut_err - e0, 1);
    i_rready = 4'b1111;

    // Async reset while master 3 holds a grant.
    repeat (2) step();
    chk("pre_reset_grant", o_arvalid, 1'b1);
    aresetn = 1'b0; i_arvalid = '0;
    step();
    chk("grant_reset_outputs", {o_arvalid, i_arready, i_rvalid, i_rlast, o_rid_err, o_rready}, '0);
    aresetn = 1'b1;
    o_arready = 1'b1; i_arvalid = 4'b1001;
    wait_ar(5);
    chk("post_reset_grant", hs_log[4], 0);
    wait_ar(6);

    // Async reset in the middle of a burst, then a fresh single beat.
    rbeat(8'h13, 1'b0, 1'b0);
    aresetn = 1'b0;
    step();
    chk("burst_reset_outputs", {o_arvalid, i_arready, i_rvalid, i_rlast, o_rid_err, o_rready}, '0);
    aresetn = 1'b1;
    rbeat(8'h35, 1'b1, 1'b0);

    // Synchronous reset abandoning a held grant.
    o_arready = 1'b0; i_arvalid = 4'b0010;
    repeat (3) step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    o_arready = 1'b1;
    wait_ar(7);
    chk("post_srst_grant", hs_log[6], 1);

    // Randomized traffic.
    srst = 1'b1; i_arvalid = '0; o_rvalid = 1'b0; o_rlast = 1'b0;
    step();
    srst = 1'b0;
    rq.delete();
    rb_rem = 0;
    repeat (3000) begin
      rand_drive();
      step();
      if (hs_mst >= 0) rq.push_back(hs_mst);
      if (r_hs && rb_rem > 0) rb_rem--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
